// File: rtl/fft_stage_seq.sv
// rtl/fft_stage_seq.sv - radix-2 DIT butterfly stage with time-multiplexed engines
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       frame handshake; in_scale latched on accept
//   in_real/in_imag         N packed samples, sample k at [k*DATA_WIDTH +: DATA_WIDTH]
//   tw_real/tw_imag         N/2 packed twiddles W_N^m, static while busy
//   out_valid/out_ready     processed frame handshake
//   out_real/out_imag       processed frame, same packing as the input
//   out_ovf                 saturation seen in the presented frame
//   busy                    stage is not idle
module fft_stage_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int INTEGER    = 4,
  parameter int FRACTION   = 4,
  parameter int N          = 32,
  parameter int STAGE      = 3,
  parameter int NBF        = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_scale,
  input  logic [N*DATA_WIDTH-1:0]       in_real,
  input  logic [N*DATA_WIDTH-1:0]       in_imag,
  input  logic [(N/2)*DATA_WIDTH-1:0]   tw_real,
  input  logic [(N/2)*DATA_WIDTH-1:0]   tw_imag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*DATA_WIDTH-1:0]       out_real,
  output logic [N*DATA_WIDTH-1:0]       out_imag,
  output logic                          out_ovf,
  output logic                          busy
);
  localparam int DW    = DATA_WIDTH;
  localparam int HALF  = 1 << (STAGE - 1);
  localparam int C     = N / (2 * NBF);
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int AW    = $clog2(N);
  localparam int TSTEP = N / (2 * HALF);

  // Saturation bounds of the Q format, held in the DW+2 bit sum domain.
  localparam logic signed [DW+1:0] SAT_HI = (DW+2)'((1 << (INTEGER + FRACTION - 1)) - 1);
  localparam logic signed [DW+1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic                   scale_q;
  logic                   ovf_q;
  logic signed [DW-1:0]   buf_r [N];
  logic signed [DW-1:0]   buf_i [N];

  logic [AW-1:0]          eng_p [NBF];
  logic [AW-1:0]          eng_q [NBF];
  logic signed [DW-1:0]   new_pr [NBF];
  logic signed [DW-1:0]   new_pi [NBF];
  logic signed [DW-1:0]   new_qr [NBF];
  logic signed [DW-1:0]   new_qi [NBF];
  logic [NBF-1:0]         eng_clip;

  // Optional halving, then clamp; MSB of the result flags a clip.
  function automatic logic [DW:0] sat_fn(input logic signed [DW+1:0] v, input logic sc);
    logic signed [DW+1:0] s;
    s = sc ? (v >>> 1) : v;
    if (s > SAT_HI)      sat_fn = {1'b1, SAT_HI[DW-1:0]};
    else if (s < SAT_LO) sat_fn = {1'b1, SAT_LO[DW-1:0]};
    else                 sat_fn = {1'b0, s[DW-1:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == CW'(C - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterflies of one stage touch disjoint pairs, so the engines of a cycle
  // can all read and write the buffer in place without ordering hazards.
  always_comb begin
    int b, j, p, m;
    logic signed [2*DW-1:0] br, bi, wr, wi, pr_full, pi_full, pr_sh, pi_sh;
    logic [DW:0]            pr, pi;
    logic [DW+1:0]          ar, ai, prx, pix;
    logic [DW:0]            s0, s1, s2, s3;
    for (int e = 0; e < NBF; e++) begin
      b        = int'(cnt_q) * NBF + e;
      j        = b % HALF;
      p        = (b / HALF) * 2 * HALF + j;
      m        = j * TSTEP;
      eng_p[e] = AW'(p);
      eng_q[e] = AW'(p + HALF);
      br = {{DW{buf_r[eng_q[e]][DW-1]}}, buf_r[eng_q[e]]};
      bi = {{DW{buf_i[eng_q[e]][DW-1]}}, buf_i[eng_q[e]]};
      wr = {{DW{tw_real[m*DW+DW-1]}}, tw_real[m*DW +: DW]};
      wi = {{DW{tw_imag[m*DW+DW-1]}}, tw_imag[m*DW +: DW]};
      pr_full = br * wr - bi * wi;
      pi_full = br * wi + bi * wr;
      pr_sh   = pr_full >>> FRACTION;
      pi_sh   = pi_full >>> FRACTION;
      pr      = pr_sh[DW:0];
      pi      = pi_sh[DW:0];
      ar  = {{2{buf_r[eng_p[e]][DW-1]}}, buf_r[eng_p[e]]};
      ai  = {{2{buf_i[eng_p[e]][DW-1]}}, buf_i[eng_p[e]]};
      prx = {pr[DW], pr};
      pix = {pi[DW], pi};
      s0  = sat_fn(ar + prx, scale_q);
      s1  = sat_fn(ai + pix, scale_q);
      s2  = sat_fn(ar - prx, scale_q);
      s3  = sat_fn(ai - pix, scale_q);
      new_pr[e]   = s0[DW-1:0];
      new_pi[e]   = s1[DW-1:0];
      new_qr[e]   = s2[DW-1:0];
      new_qi[e]   = s3[DW-1:0];
      eng_clip[e] = s0[DW] | s1[DW] | s2[DW] | s3[DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scale_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        buf_r[k] <= '0;
        buf_i[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            buf_r[k] <= in_real[k*DW +: DW];
            buf_i[k] <= in_imag[k*DW +: DW];
          end
          scale_q <= in_scale;
          ovf_q   <= 1'b0;
          cnt_q   <= '0;
        end
        RUN: begin
          for (int e = 0; e < NBF; e++) begin
            buf_r[eng_p[e]] <= new_pr[e];
            buf_i[eng_p[e]] <= new_pi[e];
            buf_r[eng_q[e]] <= new_qr[e];
            buf_i[eng_q[e]] <= new_qi[e];
          end
          ovf_q <= ovf_q | (|eng_clip);
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign out_real[k*DW +: DW] = buf_r[k];
    assign out_imag[k*DW +: DW] = buf_i[k];
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  // The sticky flag only describes a finished frame, so expose it in DONE.
  assign out_ovf   = (state_q == DONE) && ovf_q;

endmodule

// File: tb/tb_fft_stage_seq.sv
// tb/tb_fft_stage_seq.sv - testbench for fft_stage_seq
module tb_fft_stage_seq;
  localparam int DW = 8;
  localparam int NA = 8, SA = 3, BA = 2, CA = 2;
  localparam int NB = 32, SB = 1, BB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic a_in_valid, a_in_ready, a_in_scale, a_out_valid, a_out_ready, a_out_ovf, a_busy;
  logic [NA*DW-1:0]   a_in_real, a_in_imag, a_out_real, a_out_imag;
  logic [NA/2*DW-1:0] a_tw_real, a_tw_imag;
  logic b_in_valid, b_in_ready, b_in_scale, b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic [NB*DW-1:0]   b_in_real, b_in_imag, b_out_real, b_out_imag;
  logic [NB/2*DW-1:0] b_tw_real, b_tw_imag;

  fft_stage_seq #(.DATA_WIDTH(DW), .INTEGER(4), .FRACTION(4), .N(NA), .STAGE(SA), .NBF(BA)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_scale(a_in_scale),
    .in_real(a_in_real), .in_imag(a_in_imag), .tw_real(a_tw_real), .tw_imag(a_tw_imag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_real(a_out_real), .out_imag(a_out_imag),
    .out_ovf(a_out_ovf), .busy(a_busy));

  fft_stage_seq #(.DATA_WIDTH(DW), .INTEGER(4), .FRACTION(4), .N(NB), .STAGE(SB), .NBF(BB)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_scale(b_in_scale),
    .in_real(b_in_real), .in_imag(b_in_imag), .tw_real(b_tw_real), .tw_imag(b_tw_imag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_real(b_out_real), .out_imag(b_out_imag),
    .out_ovf(b_out_ovf), .busy(b_busy));

  int n_vec = 0, n_err = 0;
  int xr[32], xi[32], tr[32], ti[32], mr[32], mi[32];
  bit movf;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int v, input int bits);
    int r;
    r = v & ((1 << bits) - 1);
    if (r >= (1 << (bits - 1))) r -= (1 << bits);
    return r;
  endfunction

  function automatic int sat(input int v, input bit sc);
    int s;
    s = sc ? (v >>> 1) : v;
    if (s > 127)  begin movf = 1'b1; return 127;  end
    if (s < -128) begin movf = 1'b1; return -128; end
    return s;
  endfunction

  // Whole-stage reference: walk groups and spans directly from the DIT rules.
  task automatic model(input int n, input int stage, input bit sc);
    int half, p, q, m, pr, pi, ar, ai;
    half = 1 << (stage - 1);
    movf = 1'b0;
    for (int k = 0; k < n; k++) begin mr[k] = xr[k]; mi[k] = xi[k]; end
    for (int g = 0; g < n; g += 2 * half)
      for (int j = 0; j < half; j++) begin
        p = g + j; q = p + half; m = j * (n / (2 * half));
        pr = wrap((mr[q] * tr[m] - mi[q] * ti[m]) >>> 4, 9);
        pi = wrap((mr[q] * ti[m] + mi[q] * tr[m]) >>> 4, 9);
        ar = mr[p]; ai = mi[p];
        mr[p] = sat(ar + pr, sc); mi[p] = sat(ai + pi, sc);
        mr[q] = sat(ar - pr, sc); mi[q] = sat(ai - pi, sc);
      end
  endtask

  function automatic logic [255:0] pack(input int a[32], input int n);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*8 +: 8] = a[k][7:0];
    return v;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic clear();
    for (int k = 0; k < 32; k++) begin xr[k] = 0; xi[k] = 0; tr[k] = 0; ti[k] = 0; end
  endtask

  task automatic drive_a();
    logic [255:0] v;
    v = pack(xr, NA);   a_in_real = v[63:0];
    v = pack(xi, NA);   a_in_imag = v[63:0];
    v = pack(tr, NA/2); a_tw_real = v[31:0];
    v = pack(ti, NA/2); a_tw_imag = v[31:0];
  endtask

  // Called right after the accepting edge; checks latency and the frame.
  task automatic wait_result_a(input string tag, input bit sc);
    logic [255:0] v;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_scale = !sc;
    a_in_real  = {$urandom, $urandom};
    check({tag, "_busy"}, a_busy, 1);
    check({tag, "_inrdy"}, a_in_ready, 0);
    repeat (CA - 1) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_early"}, a_out_valid, 0);
    end
    @(posedge clk); @(negedge clk);
    check({tag, "_ovalid"}, a_out_valid, 1);
    model(NA, SA, sc);
    v = pack(mr, NA); check({tag, "_re"}, a_out_real, v[63:0]);
    v = pack(mi, NA); check({tag, "_im"}, a_out_imag, v[63:0]);
    check({tag, "_ovf"}, a_out_ovf, movf);
  endtask

  task automatic run_a(input string tag, input bit sc);
    drive_a();
    a_in_scale = sc;
    a_in_valid = 1'b1;
    @(posedge clk);
    wait_result_a(tag, sc);
  endtask

  task automatic release_a(input string tag);
    a_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0;
    check({tag, "_rel_ov"}, a_out_valid, 0);
    check({tag, "_rel_ir"}, a_in_ready, 1);
  endtask

  task automatic run_b(input bit sc);
    logic [255:0] v;
    v = pack(xr, NB); b_in_real = v;
    v = pack(xi, NB); b_in_imag = v;
    v = pack(tr, NB/2); b_tw_real = v[127:0];
    v = pack(ti, NB/2); b_tw_imag = v[127:0];
    b_in_scale = sc;
    b_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    b_in_scale = !sc;
    b_in_imag  = {8{$urandom}};
    check("b_early", b_out_valid, 0);
    @(posedge clk); @(negedge clk);
    check("b_ovalid", b_out_valid, 1);
    model(NB, SB, sc);
    check("b_re", b_out_real, pack(mr, NB));
    check("b_im", b_out_imag, pack(mi, NB));
    check("b_ovf", b_out_ovf, movf);
    for (int i = 0; i < 8; i++) begin
      b_out_ready = (i == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      if (b_out_ready) break;
      check("b_hold", b_out_valid, 1);
    end
    b_out_ready = 1'b0;
    check("b_rel_ov", b_out_valid, 0);
    check("b_rel_ir", b_in_ready, 1);
  endtask

  initial begin
    logic [255:0] v;
    reset = 1'b1;
    a_in_valid = 0; a_in_scale = 0; a_out_ready = 0;
    a_in_real = '0; a_in_imag = '0; a_tw_real = '0; a_tw_imag = '0;
    b_in_valid = 0; b_in_scale = 0; b_out_ready = 0;
    b_in_real = '0; b_in_imag = '0; b_tw_real = '0; b_tw_imag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_inrdy", a_in_ready, 1);
    check("rst_ovalid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ovf", a_out_ovf, 0);
    check("rst_re", a_out_real, 0);
    check("rst_im", a_out_imag, 0);
    check("rst_b_inrdy", b_in_ready, 1);

    clear();
    for (int k = 0; k < 4; k++) tr[k] = 16;
    xr[0] = 16; xr[4] = 32;
    run_a("t1", 0);
    check("t1_out0", a_out_real[7:0], 8'd48);
    check("t1_out4", a_out_real[39:32], 8'hF0);
    release_a("t1");

    clear();
    for (int k = 0; k < 4; k++) tr[k] = 16;
    tr[2] = 0; ti[2] = -16; xr[2] = 16; xr[6] = 16;
    run_a("t2", 0);
    check("t2_out2r", a_out_real[23:16], 8'd16);
    check("t2_out2i", a_out_imag[23:16], 8'hF0);
    check("t2_out6r", a_out_real[55:48], 8'd16);
    check("t2_out6i", a_out_imag[55:48], 8'd16);
    release_a("t2");

    clear();
    for (int k = 0; k < 4; k++) tr[k] = 16;
    xr[0] = 112; xr[4] = 32;
    run_a("t3s0", 0);
    check("t3s0_out0", a_out_real[7:0], 8'd127);
    check("t3s0_out4", a_out_real[39:32], 8'd80);
    check("t3s0_ovf1", a_out_ovf, 1);
    release_a("t3s0");
    run_a("t3s1", 1);
    check("t3s1_out0", a_out_real[7:0], 8'd72);
    check("t3s1_out4", a_out_real[39:32], 8'd40);
    check("t3s1_ovf0", a_out_ovf, 0);
    release_a("t3s1");

    clear();
    for (int k = 0; k < 4; k++) tr[k] = 16;
    xr[0] = 16; xr[4] = 32;
    run_a("t4a", 0);
    v = pack(mr, NA);
    for (int k = 0; k < NA; k++) begin xr[k] = rnd8(); xi[k] = rnd8(); end
    drive_a();
    a_in_scale = 1'b0;
    a_in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      check("t4_hold_re", a_out_real, v[63:0]);
      check("t4_hold_ir", a_in_ready, 0);
      check("t4_hold_ov", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0;
    check("t4_idle_ir", a_in_ready, 1);
    check("t4_idle_ov", a_out_valid, 0);
    @(posedge clk);
    wait_result_a("t4b", 0);
    release_a("t4b");

    clear();
    for (int k = 0; k < 4; k++) tr[k] = 16;
    xr[0] = 16; xr[4] = 32;
    drive_a();
    a_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("t5_ir", a_in_ready, 1);
    check("t5_ov", a_out_valid, 0);
    check("t5_busy", a_busy, 0);
    check("t5_re", a_out_real, 0);
    check("t5_im", a_out_imag, 0);
    tr[2] = 0; ti[2] = -16; xr[0] = 0; xr[4] = 0; xr[2] = 16; xr[6] = 16;
    run_a("t5post", 0);
    release_a("t5post");

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < NA; k++) begin xr[k] = rnd8(); xi[k] = rnd8(); end
      for (int k = 0; k < NA/2; k++) begin tr[k] = rnd8(); ti[k] = rnd8(); end
      run_a("arnd", 1'($urandom_range(0, 1)));
      release_a("arnd");
    end

    for (int f = 0; f < 200; f++) begin
      for (int k = 0; k < NB; k++) begin xr[k] = rnd8(); xi[k] = rnd8(); end
      for (int k = 0; k < NB/2; k++) begin tr[k] = rnd8(); ti[k] = rnd8(); end
      run_b(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
